// File: rtl/div_pkg.sv
// Shared constants, state encoding and operation decode for the iterative RV32M divider.
package div_pkg;

  localparam int unsigned LENGTH     = 32;
  localparam int unsigned ITERATIONS = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    CALC = S_CALC,
    FIX  = S_FIX,
    DONE = S_DONE
  } state_t;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [LENGTH-1:0] QUOT_ALL_ONES = '1;
  localparam logic [LENGTH-1:0] INT_MIN       = {1'b1, {(LENGTH-1){1'b0}}};

  function automatic logic is_signed_op(input logic [1:0] f);
    return (f == OP_DIV) || (f == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] f);
    return (f == OP_REM) || (f == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial subtract, pick quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned length = LENGTH
) (
  input  logic [length:0]   rem,
  input  logic [length-1:0] quo,
  input  logic [length-1:0] dmag,
  output logic [length:0]   rem_next,
  output logic [length-1:0] quo_next
);

  logic [length+1:0] shifted;
  logic [length+1:0] trial;

  always_comb begin
    shifted  = {rem, quo[length-1]};
    // Top bit of the widened difference is the borrow: set means trial < 0.
    trial    = shifted - {2'b00, dmag};
    rem_next = trial[length+1] ? shifted[length:0] : trial[length:0];
    quo_next = {quo[length-2:0], ~trial[length+1]};
  end

endmodule

// File: rtl/div_iterative.sv
// Sequential 32-cycle restoring divider for DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish straight from IDLE.
module div_iterative
  import div_pkg::*;
#(
  parameter int unsigned length = LENGTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_div,
  input  logic [1:0]        fuct3,
  input  logic [length-1:0] dividend,
  input  logic [length-1:0] divisor,
  output logic [length-1:0] div_o,
  output logic              div_finish,
  output logic              div_busy
);

  // Special-case constants are RV32M values; length is expected to stay 32.
  localparam logic [length-1:0] all_ones = length'(QUOT_ALL_ONES);
  localparam logic [length-1:0] int_min  = length'(INT_MIN);

  state_t            state;
  logic [5:0]        cnt;
  logic [length:0]   rem;
  logic [length-1:0] quo;
  logic [length-1:0] dvd;
  logic [length-1:0] dvs;
  logic [1:0]        op;

  logic [length-1:0] a_mag;
  logic [length-1:0] dmag;
  logic [length:0]   step_rem;
  logic [length-1:0] step_quo;

  function automatic logic [length-1:0] final_result(
    input logic [1:0]        f,
    input logic [length-1:0] a,
    input logic [length-1:0] b,
    input logic [length-1:0] q,
    input logic [length-1:0] r
  );
    logic rem_sel;
    logic ovf;
    rem_sel = is_rem_op(f);
    ovf     = is_signed_op(f) && (a == int_min) && (b == all_ones);
    if (b == '0) return rem_sel ? a : all_ones;
    if (ovf)     return rem_sel ? '0 : int_min;
    case (f)
      OP_DIV:  return (a[length-1] ^ b[length-1]) ? ('0 - q) : q;
      OP_DIVU: return q;
      OP_REM:  return a[length-1] ? ('0 - r) : r;
      default: return r;
    endcase
  endfunction

  always_comb begin
    a_mag = (is_signed_op(fuct3) && dividend[length-1]) ? ('0 - dividend) : dividend;
    dmag  = (is_signed_op(op) && dvs[length-1]) ? ('0 - dvs) : dvs;
  end

`ifdef DIV_EARLY_OUT_EN
  logic in_special;
  always_comb begin
    in_special = (divisor == '0) ||
                 (is_signed_op(fuct3) && (dividend == int_min) && (divisor == all_ones));
  end
`endif

  div_step #(.length(length)) u_step (
    .rem      (rem),
    .quo      (quo),
    .dmag     (dmag),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      op    <= OP_DIV;
      div_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_div) begin
            op  <= fuct3;
            dvd <= dividend;
            dvs <= divisor;
            rem <= '0;
            quo <= a_mag;
            cnt <= '0;
`ifdef DIV_EARLY_OUT_EN
            if (in_special) begin
              div_o <= final_result(fuct3, dividend, divisor, '0, '0);
              state <= DONE;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          rem <= step_rem;
          quo <= step_quo;
          if (cnt == 6'(ITERATIONS - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        FIX: begin
          div_o <= final_result(op, dvd, dvs, quo, rem[length-1:0]);
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    div_busy   = (state == CALC) || (state == FIX);
    div_finish = (state == DONE);
  end

endmodule

// File: tb/tb_div_iterative.sv
// Self-checking bench for div_iterative: arithmetic reference model plus directed literal cases.
module tb_div_iterative;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_div = 1'b0;
  logic [1:0]  fuct3 = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] div_o;
  logic        div_finish;
  logic        div_busy;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;

  div_iterative #(.length(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_div (enable_div),
    .fuct3      (fuct3),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_o      (div_o),
    .div_finish (div_finish),
    .div_busy   (div_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic is_special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M semantics expressed directly with SV arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    case (f)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic int unsigned ref_lat(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    return is_special(f, a, b) ? 0 : 33;
`else
    return is_special(f, a, b) ? 33 : 33;
`endif
  endfunction

  // Transaction-level model: one op in flight, result appears m_fin edges after the start edge.
  logic        m_active = 1'b0;
  int unsigned m_start = 0;
  int unsigned m_fin = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_out = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_active = 1'b0;
      m_out    = '0;
    end else if (!m_active) begin
      if (enable_div) begin
        m_active = 1'b1;
        m_start  = cyc;
        m_res    = ref_div(fuct3, dividend, divisor);
        m_fin    = ref_lat(fuct3, dividend, divisor);
        if (m_fin == 0) m_out = m_res;
      end
    end else begin
      if (cyc - m_start == m_fin) m_out = m_res;
      if (cyc - m_start == m_fin + 1) m_active = 1'b0;
    end
  end

  always @(negedge clk) begin
    int unsigned n;
    n = cyc - m_start;
    check("div_o", div_o, m_out);
    check("div_finish", {31'd0, div_finish}, {31'd0, m_active && n == m_fin});
    check("div_busy", {31'd0, div_busy}, {31'd0, m_active && n < m_fin});
  end

  task automatic start_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    fuct3 = f; dividend = a; divisor = b; enable_div = 1'b1;
    @(negedge clk);
    enable_div = 1'b0;
    dividend = $urandom; divisor = $urandom; fuct3 = 2'($urandom);
  endtask

  task automatic wait_done(input string name, input int unsigned exp_wait,
                           input logic [31:0] lit, input bit use_lit);
    int unsigned waited = 0;
    while (!div_finish && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_latency"}, waited, exp_wait);
    if (use_lit) check(name, div_o, lit);
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [1:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input bit use_lit);
    int unsigned lat;
    lat = ref_lat(f, a, b);
    start_op(f, a, b);
    wait_done(name, lat, lit, use_lit);
  endtask

  task automatic quiet_window(input string name, input int unsigned cycles);
    int unsigned pulses = 0;
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (div_finish || div_busy) pulses++;
    end
    check(name, pulses, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_div_o", div_o, 32'd0);
    check("reset_finish", {31'd0, div_finish}, 32'd0);
    check("reset_busy", {31'd0, div_busy}, 32'd0);
    rst = 1'b0;

    run_op("divu_100_7",  2'b01, 32'd100, 32'd7, 32'd14, 1'b1);
    run_op("remu_100_7",  2'b11, 32'd100, 32'd7, 32'd2, 1'b1);
    run_op("div_m7_2",    2'b00, -32'sd7, 32'd2, 32'hFFFF_FFFD, 1'b1);
    run_op("rem_m7_2",    2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 1'b1);
    run_op("rem_7_m2",    2'b10, 32'd7, -32'sd2, 32'd1, 1'b1);
    run_op("div_5_0",     2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_op("remu_5_0",    2'b11, 32'd5, 32'd0, 32'd5, 1'b1);
    run_op("rem_m5_0",    2'b10, -32'sd5, 32'd0, 32'hFFFF_FFFB, 1'b1);
    run_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);

    // New start request 10 cycles into an op must be ignored.
    start_op(2'b01, 32'd1000, 32'd9);
    repeat (10) @(negedge clk);
    fuct3 = 2'b00; dividend = 32'd50; divisor = 32'd5; enable_div = 1'b1;
    @(negedge clk);
    enable_div = 1'b0;
    wait_done("busy_ignore", 22, 32'd111, 1'b1);
    quiet_window("busy_ignore_no_second_op", 40);

    // Reset 15 cycles into an op aborts it.
    start_op(2'b00, 32'd12345, 32'd67);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, div_busy}, 32'd0);
    check("midrst_div_o", div_o, 32'd0);
    check("midrst_finish", {31'd0, div_finish}, 32'd0);
    rst = 1'b0;
    quiet_window("midrst_no_finish", 40);
    run_op("divu_ffffffff_3", 2'b01, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 1'b1);

    for (int unsigned k = 0; k < 40; k++) begin
      logic [1:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      int unsigned sel;
      f = 2'($urandom);
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 20));
      else if (sel == 3) b = -32'sd3;
      run_op("random", f, a, b, 32'd0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
